// File: rtl/rpn_pkg.sv
// rpn_pkg: shared state and opcode encodings for the RPN stack calculator.
package rpn_pkg;

    localparam logic [2:0] ST_ERROR = 3'b111;

    typedef enum logic [2:0] {
        S_WAIT  = 3'b000,
        S_PUSH  = 3'b001,
        S_EXEC  = 3'b010,
        S_WB    = 3'b011,
        S_ERROR = ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101
    } opcode_t;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational RPN operator unit, results truncated to WIDTH bits.
// Multiply (opcode 101) exists only when RPN_MUL_EN is defined; otherwise it is flagged illegal.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          op,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
`ifdef RPN_MUL_EN
            OP_MUL:  result = a * b;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: RPN calculator controller with an operand stack and sticky error flags.
// Opcode 101 (multiply) is legal only when RPN_MUL_EN is defined (see rpn_alu).
module rpn_stack_calc
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_pulse,
    input  logic             is_op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       opcode_in,
    output logic [WIDTH-1:0] top_value,
    output logic [CNT_W-1:0] depth,
    output logic [2:0]       status,
    output logic             busy,
    output logic             result_valid,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             err_badop
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t           state, next;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] hold_data, result_reg, alu_result;
    opcode_t          hold_op, alu_op;
    logic             alu_illegal, push_en, wb_en, clr, ld_hold;
    logic             set_ovf, set_unf, set_bad, valid;
    logic [IDX_W-1:0] top_idx, sec_idx, push_idx;

    assign top_idx  = IDX_W'(depth - CNT_W'(1));
    assign sec_idx  = IDX_W'(depth - CNT_W'(2));
    assign push_idx = IDX_W'(depth);
    // In WAIT the ALU only judges legality of the incoming opcode; in EXEC it computes.
    assign alu_op   = (state == S_WAIT) ? opcode_t'(opcode_in) : hold_op;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a       (stack[sec_idx]),
        .b       (stack[top_idx]),
        .op      (alu_op),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    always_comb begin
        next    = S_WAIT;
        push_en = 1'b0;
        wb_en   = 1'b0;
        clr     = 1'b0;
        ld_hold = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_bad = 1'b0;
        case (state)
            S_WAIT: begin
                ld_hold = enter_pulse;
                if (enter_pulse && !is_op) begin
                    set_ovf = depth == CNT_W'(DEPTH);
                    next    = set_ovf ? S_ERROR : S_PUSH;
                end else if (enter_pulse) begin
                    set_unf = depth < CNT_W'(2);
                    set_bad = !set_unf && alu_illegal;
                    next    = (set_unf || set_bad) ? S_ERROR : S_EXEC;
                end
            end
            S_PUSH:  push_en = 1'b1;
            S_EXEC:  next = S_WB;
            S_WB:    wb_en = 1'b1;
            S_ERROR: begin
                clr  = enter_pulse;
                next = enter_pulse ? S_WAIT : S_ERROR;
            end
            default: next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_WAIT;
            depth         <= '0;
            hold_data     <= '0;
            hold_op       <= OP_ADD;
            result_reg    <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_badop     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            state <= next;
            if (ld_hold) begin
                hold_data <= data_in;
                hold_op   <= opcode_t'(opcode_in);
            end
            if (state == S_EXEC) result_reg <= alu_result;
            if (clr) begin
                depth <= '0;
                for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            end else if (push_en) begin
                stack[push_idx] <= hold_data;
                depth           <= depth + CNT_W'(1);
            end else if (wb_en) begin
                stack[sec_idx] <= result_reg;
                depth          <= depth - CNT_W'(1);
            end
            err_overflow  <= !clr && (err_overflow || set_ovf);
            err_underflow <= !clr && (err_underflow || set_unf);
            err_badop     <= !clr && (err_badop || set_bad);
        end
    end

    always_comb begin
        valid        = state inside {S_WAIT, S_PUSH, S_EXEC, S_WB, S_ERROR};
        status       = valid ? state : 3'b000;
        busy         = state inside {S_PUSH, S_EXEC, S_WB};
        result_valid = state == S_WB;
        top_value    = (valid && depth != '0) ? stack[top_idx] : '0;
    end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// tb_rpn_stack_calc: directed and random stimulus against a transaction-level stack model.
module tb_rpn_stack_calc;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);
`ifdef RPN_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    logic          clk = 1'b0, reset = 1'b1, enter_pulse = 1'b0, is_op = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [2:0]    opcode_in = '0;
    logic [W-1:0]  top_value;
    logic [CW-1:0] depth;
    logic [2:0]    status;
    logic          busy, result_valid, err_overflow, err_underflow, err_badop;

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] ms[$];
    bit           m_ovf, m_unf, m_bad, m_err, m_push;
    int           m_busy;
    logic [W-1:0] m_pend;

    always #5 clk = ~clk;

    rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .enter_pulse   (enter_pulse),
        .is_op         (is_op),
        .data_in       (data_in),
        .opcode_in     (opcode_in),
        .top_value     (top_value),
        .depth         (depth),
        .status        (status),
        .busy          (busy),
        .result_valid  (result_valid),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_badop     (err_badop)
    );

    function automatic logic [W-1:0] calc(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return a * b;
        endcase
    endfunction

    task automatic check(input string n, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: an accepted entry completes after 1 (push) or 2 (operator) busy cycles.
    always @(posedge clk) begin
        if (reset) begin
            ms.delete();
            {m_ovf, m_unf, m_bad, m_err, m_push} = '0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) begin
                if (!m_push) begin
                    void'(ms.pop_back());
                    void'(ms.pop_back());
                end
                ms.push_back(m_pend);
            end
        end else if (m_err) begin
            if (enter_pulse) begin
                ms.delete();
                {m_ovf, m_unf, m_bad, m_err} = '0;
            end
        end else if (enter_pulse) begin
            if (!is_op) begin
                if (ms.size() == D) {m_ovf, m_err} = 2'b11;
                else begin
                    m_push = 1'b1;
                    m_pend = data_in;
                    m_busy = 1;
                end
            end else if (ms.size() < 2) {m_unf, m_err} = 2'b11;
            else if (opcode_in > 5 || (opcode_in == 5 && !MUL)) {m_bad, m_err} = 2'b11;
            else begin
                m_push = 1'b0;
                m_pend = calc(int'(opcode_in), ms[ms.size() - 2], ms[$]);
                m_busy = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("top_value", top_value, ms.size() != 0 ? ms[$] : 0);
            check("depth", depth, ms.size());
            check("status", status, m_err ? 7 : m_busy == 0 ? 0 : m_push ? 1 : m_busy == 2 ? 2 : 3);
            check("busy", busy, m_busy > 0);
            check("result_valid", result_valid, !m_push && m_busy == 1);
            check("err_overflow", err_overflow, m_ovf);
            check("err_underflow", err_underflow, m_unf);
            check("err_badop", err_badop, m_bad);
        end
    end

    task automatic pulse(input bit op, input logic [W-1:0] d, input logic [2:0] oc);
        enter_pulse = 1'b1;
        is_op       = op;
        data_in     = d;
        opcode_in   = oc;
        @(negedge clk);
        enter_pulse = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        pulse(1'b0, d, 3'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_top", top_value, 0);
        check("rst_depth", depth, 0);
        check("rst_status", status, 0);
        check("rst_flags", {busy, result_valid, err_overflow, err_underflow, err_badop}, 0);

        push(7); push(5); pulse(1'b1, 0, 3'd1);
        check("d1_exec", status, 2);
        @(negedge clk);
        check("d1_rv", result_valid, 1);
        check("d1_wb", status, 3);
        @(negedge clk);
        check("d1_top", top_value, 2);
        check("d1_depth", depth, 1);
        check("d1_rv_off", result_valid, 0);

        do_reset();
        push(16'h0000); push(16'h0001); pulse(1'b1, 0, 3'd1);
        repeat (2) @(negedge clk);
        check("d2_wrap_sub", top_value, 16'hFFFF);
        push(16'h0001); pulse(1'b1, 0, 3'd0);
        repeat (2) @(negedge clk);
        check("d2_wrap_add", top_value, 16'h0000);
        check("d2_depth", depth, 1);

        do_reset();
        for (int i = 1; i <= 4; i++) push(W'(i * 3));
        pulse(1'b0, 9, 3'd0);
        check("d3_status", status, 7);
        check("d3_ovf", err_overflow, 1);
        check("d3_depth", depth, 4);
        check("d3_top", top_value, 12);
        pulse(1'b1, 0, 3'd0);
        check("d3_clr_depth", depth, 0);
        check("d3_clr_ovf", err_overflow, 0);
        check("d3_clr_status", status, 0);

        do_reset();
        push(3); pulse(1'b1, 0, 3'd0);
        check("d4_unf", err_underflow, 1);
        check("d4_status", status, 7);
        check("d4_unf_bad", err_badop, 0);
        pulse(1'b0, 0, 3'd0);
        push(1); push(2); pulse(1'b1, 0, 3'b110);
        check("d4_bad", err_badop, 1);
        check("d4_bad_unf", err_underflow, 0);
        check("d4_bad_depth", depth, 2);
        pulse(1'b0, 0, 3'd0);

        push(6); push(7); pulse(1'b1, 0, 3'b101);
        repeat (2) @(negedge clk);
        check("d5_top", top_value, MUL ? 42 : 7);
        check("d5_depth", depth, MUL ? 1 : 2);
        check("d5_bad", err_badop, MUL ? 0 : 1);

        do_reset();
        enter_pulse = 1'b1; is_op = 1'b0; data_in = 11;
        @(negedge clk);
        data_in = 22;
        @(negedge clk);
        enter_pulse = 1'b0;
        @(negedge clk);
        check("d6_depth", depth, 1);
        check("d6_top", top_value, 11);

        push(2); pulse(1'b1, 0, 3'd0);
        reset = 1'b1;
        @(negedge clk);
        check("d7_depth", depth, 0);
        check("d7_rv", result_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("d7_rv2", result_valid, 0);
        check("d7_top", top_value, 0);

        repeat (4000) begin
            enter_pulse = $urandom_range(0, 9) < 4;
            is_op       = $urandom_range(0, 9) < 4;
            data_in     = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 3)) : W'($urandom);
            opcode_in   = 3'($urandom_range(0, 7));
            reset       = $urandom_range(0, 299) == 0;
            @(negedge clk);
        end
        reset = 1'b0;
        enter_pulse = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
